// File: rtl/aig_seq_eval.sv
// Sequential AND-inverter graph evaluator: one node per cycle over a programmable node table,
// producing either a single output bit or the complete truth table of the output literal.
module aig_seq_eval #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned MAX_NODES  = 16,
  localparam int unsigned IDX_W = $clog2(1 + NUM_INPUTS + MAX_NODES),
  localparam int unsigned LIT_W = IDX_W + 1,
  localparam int unsigned ADR_W = $clog2(MAX_NODES),
  localparam int unsigned NN_W  = ADR_W + 1,
  localparam int unsigned TT_W  = 2 ** NUM_INPUTS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [ADR_W-1:0]      cfg_addr,
  input  logic [LIT_W-1:0]      cfg_lit0,
  input  logic [LIT_W-1:0]      cfg_lit1,
  input  logic [NN_W-1:0]       cfg_num_nodes,
  input  logic [LIT_W-1:0]      cfg_out_lit,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_INPUTS-1:0] in_x,
  input  logic                  in_tt_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_y,
  output logic [TT_W-1:0]       out_tt,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned VEC_W = 2 ** IDX_W;
  localparam int unsigned LIM_W = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESOLVE, S_DONE} state_t;

  state_t                state;
  logic [LIT_W-1:0]      lit0_tab [MAX_NODES];
  logic [LIT_W-1:0]      lit1_tab [MAX_NODES];
  logic [MAX_NODES-1:0]  node_val;
  logic [NUM_INPUTS-1:0] x_q;
  logic [ADR_W-1:0]      ptr;
  logic [NN_W-1:0]       num_nodes_q;
  logic [LIT_W-1:0]      out_lit_q;
  logic                  tt_mode_q;

  logic [VEC_W-1:0]      val_vec;
  logic [LIM_W-1:0]      eval_lim;
  logic [LIM_W-1:0]      out_lim;
  logic [1:0]            fan0;
  logic [1:0]            fan1;
  logic [1:0]            outr;
  logic [NN_W-1:0]       req_nn;
  logic                  req_clamp;
  logic                  last_node;

  // Returns {illegal, value}; indices at or beyond the limit read as 0 before complement.
  function automatic logic [1:0] read_lit(input logic [LIT_W-1:0] lit,
                                          input logic [LIM_W-1:0] limit,
                                          input logic [VEC_W-1:0] vals);
    logic [IDX_W-1:0] idx;
    logic             legal;
    logic             v;
    idx   = lit[LIT_W-1:1];
    legal = LIM_W'(idx) < limit;
    v     = legal ? vals[idx] : 1'b0;
    return {~legal, v ^ lit[0]};
  endfunction

  // Value vector indexed by literal index: const 0, primary inputs, then node results.
  always_comb begin
    val_vec   = VEC_W'({node_val, x_q, 1'b0});
    eval_lim  = LIM_W'(NUM_INPUTS + 1) + LIM_W'(ptr);
    out_lim   = LIM_W'(NUM_INPUTS + 1) + LIM_W'(num_nodes_q);
    fan0      = read_lit(lit0_tab[ptr], eval_lim, val_vec);
    fan1      = read_lit(lit1_tab[ptr], eval_lim, val_vec);
    outr      = read_lit(out_lit_q, out_lim, val_vec);
    req_clamp = cfg_num_nodes > NN_W'(MAX_NODES);
    req_nn    = req_clamp ? NN_W'(MAX_NODES) : cfg_num_nodes;
    last_node = NN_W'(ptr) == (num_nodes_q - NN_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_y       <= 1'b0;
      out_tt      <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
      node_val    <= '0;
      x_q         <= '0;
      ptr         <= '0;
      num_nodes_q <= '0;
      out_lit_q   <= '0;
      tt_mode_q   <= 1'b0;
      for (int i = 0; i < int'(MAX_NODES); i++) begin
        lit0_tab[i] <= '0;
        lit1_tab[i] <= '0;
      end
    end else begin
      if (cfg_we && state == S_IDLE) begin
        lit0_tab[cfg_addr] <= cfg_lit0;
        lit1_tab[cfg_addr] <= cfg_lit1;
      end
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            num_nodes_q <= req_nn;
            out_lit_q   <= cfg_out_lit;
            tt_mode_q   <= in_tt_mode;
            err         <= req_clamp;
            x_q         <= in_tt_mode ? '0 : in_x;
            ptr         <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
            state       <= (req_nn == '0) ? S_RESOLVE : S_EVAL;
          end
        end
        S_EVAL: begin
          node_val[ptr] <= fan0[0] & fan1[0];
          if (fan0[1] || fan1[1]) err <= 1'b1;
          if (last_node) state <= S_RESOLVE;
          else           ptr   <= ptr + ADR_W'(1);
        end
        S_RESOLVE: begin
          if (outr[1]) err <= 1'b1;
          if (!tt_mode_q) begin
            out_y     <= outr[0];
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            out_tt[x_q] <= outr[0];
            if (&x_q) begin
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              x_q   <= x_q + NUM_INPUTS'(1);
              ptr   <= '0;
              state <= (num_nodes_q == '0) ? S_RESOLVE : S_EVAL;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
